// File: rtl/filter_sample_gen.sv
// Valid/ready stimulus source for the 8-bit filter x port: impulse, step, square, sawtooth and
// (with FILTER_SAMPLE_GEN_LFSR_EN defined) a 16-bit Fibonacci LFSR stream.
module filter_sample_gen #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned PERIOD_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [2:0]          mode,
   input  logic [DATA_W-1:0]   amplitude,
   input  logic [PERIOD_W-1:0] period,
   input  logic [15:0]         num_samples,
   output logic [DATA_W-1:0]   x_out,
   output logic                x_valid,
   input  logic                x_ready,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          mode_q;
   logic [DATA_W-1:0]   amp_q;
   logic [DATA_W-1:0]   ramp_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] ph_q;
   logic                sq_hi_q;
   logic [15:0]         num_q;
   logic [15:0]         cnt_q;
   logic [15:0]         cnt_inc;
   logic                accept;
   logic                xfer;
   logic                last;
   logic [DATA_W-1:0]   lfsr_sample;
   logic [DATA_W-1:0]   sample;

   // stop beats a same-cycle start
   assign accept  = (state_q == StIdle) && start && !stop;
   assign xfer    = (state_q == StRun) && x_ready;
   assign cnt_inc = cnt_q + 16'd1;
   assign last    = xfer && (num_q != 16'd0) && (cnt_inc == num_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun: begin
            if (stop) begin
               state_d = StIdle;
            end else if (last) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q   <= '0;
         amp_q    <= '0;
         period_q <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
         ramp_q   <= '0;
         ph_q     <= '0;
         sq_hi_q  <= 1'b0;
      end else if (accept) begin
         mode_q   <= mode;
         amp_q    <= amplitude;
         period_q <= (period == '0) ? PERIOD_W'(1) : period;
         num_q    <= num_samples;
         cnt_q    <= '0;
         ramp_q   <= '0;
         ph_q     <= '0;
         sq_hi_q  <= 1'b1;
      end else if (xfer) begin
         cnt_q  <= cnt_inc;
         ramp_q <= ramp_q + amp_q;
         // ph_q counts samples within the current half-period
         if (ph_q == period_q - PERIOD_W'(1)) begin
            ph_q    <= '0;
            sq_hi_q <= !sq_hi_q;
         end else begin
            ph_q <= ph_q + PERIOD_W'(1);
         end
      end
   end

`ifdef FILTER_SAMPLE_GEN_LFSR_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   // x^16+x^14+x^13+x^11+1, shifting right
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= '0;
      end else if (accept) begin
         lfsr_q <= 16'hACE1;
      end else if (xfer) begin
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      end
   end

   assign lfsr_sample = lfsr_q[DATA_W-1:0];
`else
   assign lfsr_sample = '0;
`endif

   always_comb begin
      sample = '0;
      unique case (mode_q)
         3'd0:    sample = (cnt_q == 16'd0) ? amp_q : '0;
         3'd1:    sample = amp_q;
         3'd2:    sample = sq_hi_q ? amp_q : '0;
         3'd3:    sample = ramp_q;
         3'd4:    sample = lfsr_sample;
         default: sample = '0;
      endcase
   end

   assign x_out   = (state_q == StRun) ? sample : '0;
   assign x_valid = (state_q == StRun);
   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);

endmodule

// File: tb/tb_filter_sample_gen.sv
// Scoreboard bench for filter_sample_gen; honours FILTER_SAMPLE_GEN_LFSR_EN for the mode-4 test.
module tb_filter_sample_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [2:0]  mode;
   logic [7:0]  amplitude;
   logic [7:0]  period;
   logic [15:0] num_samples;
   logic [7:0]  x_out;
   logic        x_valid;
   logic        x_ready;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   filter_sample_gen #(.DATA_W(8), .PERIOD_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .mode       (mode),
      .amplitude  (amplitude),
      .period     (period),
      .num_samples(num_samples),
      .x_out      (x_out),
      .x_valid    (x_valid),
      .x_ready    (x_ready),
      .busy       (busy),
      .done       (done)
   );

   // Drives a one-cycle start pulse; returns at the negedge after the latching edge.
   task automatic pulse_start(input logic [2:0] m, input logic [7:0] a, input logic [7:0] p,
                              input logic [15:0] n);
      @(negedge clk);
      mode = m; amplitude = a; period = p; num_samples = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // later input changes must not affect the running stream
      mode = 3'd7; amplitude = 8'h00; period = 8'h09; num_samples = 16'd1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (x_out !== 8'h00) begin fails++; $display("FAIL reset_x_out: got %h want 00", x_out); end
      tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL reset_x_valid: got %b want 0", x_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_impulse;
      int got = 0;
      int cyc = 0;
      logic [7:0] exp;
      sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
      x_ready = 1'b1;
      pulse_start(3'd0, 8'h01, 8'h00, 16'd4);
      tests++; if (x_valid !== 1'b1) begin fails++; $display("FAIL impulse_latency: x_valid %b want 1", x_valid); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL impulse_busy: got %b want 1", busy); end
      while (got < 4 && cyc < 40) begin
         if (x_valid && x_ready) begin
            exp = sb.pop_front();
            tests++; if (x_out !== exp) begin fails++; $display("FAIL impulse_k%0d: got %h want %h", got, x_out, exp); end
            got++;
         end
         @(negedge clk); cyc++;
      end
      tests++; if (got != 4) begin fails++; $display("FAIL impulse_timeout: got %0d transfers want 4", got); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL impulse_done: got %b want 1", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL impulse_done_busy: got %b want 0", busy); end
      tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL impulse_valid_drop: got %b want 0", x_valid); end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL impulse_done_pulse: got %b want 0", done); end
      sb.delete();
   endtask

   task automatic test_square;
      logic [7:0] exp;
      for (int pass = 0; pass < 2; pass++) begin
         int got = 0;
         int cyc = 0;
         if (pass == 0) begin
            sb.push_back(8'h7F); sb.push_back(8'h7F); sb.push_back(8'h00); sb.push_back(8'h00);
            sb.push_back(8'h7F); sb.push_back(8'h7F); sb.push_back(8'h00); sb.push_back(8'h00);
         end else begin
            for (int i = 0; i < 8; i++) sb.push_back((i % 2 == 0) ? 8'h7F : 8'h00);
         end
         x_ready = 1'b1;
         pulse_start(3'd2, 8'h7F, (pass == 0) ? 8'd2 : 8'd0, 16'd8);
         while (got < 8 && cyc < 40) begin
            if (x_valid && x_ready) begin
               exp = sb.pop_front();
               tests++; if (x_out !== exp) begin fails++; $display("FAIL square_p%0d_k%0d: got %h want %h", pass, got, x_out, exp); end
               got++;
            end
            @(negedge clk); cyc++;
         end
         tests++; if (got != 8) begin fails++; $display("FAIL square_timeout: got %0d transfers want 8", got); end
         tests++; if (done !== 1'b1) begin fails++; $display("FAIL square_done: got %b want 1", done); end
         sb.delete();
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int got = 0;
      int cyc = 0;
      logic [7:0] exp;
      sb.push_back(8'h00); sb.push_back(8'h40); sb.push_back(8'h80); sb.push_back(8'hC0);
      sb.push_back(8'h00);
      x_ready = 1'b1;
      pulse_start(3'd3, 8'h40, 8'h00, 16'd5);
      exp = sb.pop_front();
      tests++; if (x_out !== exp) begin fails++; $display("FAIL saw_k0: got %h want %h", x_out, exp); end
      got = 1;
      @(negedge clk);
      x_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++; if (x_out !== 8'h40 || x_valid !== 1'b1) begin
            fails++; $display("FAIL saw_stall%0d: got %h/%b want 40/1", i, x_out, x_valid);
         end
      end
      x_ready = 1'b1;
      while (got < 5 && cyc < 40) begin
         if (x_valid && x_ready) begin
            exp = sb.pop_front();
            tests++; if (x_out !== exp) begin fails++; $display("FAIL saw_k%0d: got %h want %h", got, x_out, exp); end
            got++;
         end
         @(negedge clk); cyc++;
      end
      tests++; if (got != 5) begin fails++; $display("FAIL saw_timeout: got %0d transfers want 5", got); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL saw_done: got %b want 1", done); end
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_abort;
      int got = 0;
      logic [7:0] exp;
      sb.push_back(8'h55); sb.push_back(8'h55); sb.push_back(8'h55);
      x_ready = 1'b1;
      pulse_start(3'd1, 8'h55, 8'h00, 16'd10);
      while (got < 2) begin
         exp = sb.pop_front();
         tests++; if (x_out !== exp) begin fails++; $display("FAIL abort_k%0d: got %h want %h", got, x_out, exp); end
         got++;
         @(negedge clk);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", x_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done%0d: got %b want 0", i, done); end
         @(negedge clk);
      end
      sb.delete();
      // start and stop together in IDLE
      mode = 3'd1; amplitude = 8'h11; num_samples = 16'd4; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL startstop_busy: got %b want 0", busy); end
      @(negedge clk);
      tests++; if (x_valid !== 1'b0) begin fails++; $display("FAIL startstop_valid: got %b want 0", x_valid); end
   endtask

   task automatic test_reset_midstream;
      x_ready = 1'b1;
      pulse_start(3'd1, 8'hAA, 8'h00, 16'd10);
      tests++; if (x_out !== 8'hAA) begin fails++; $display("FAIL midrst_k0: got %h want aa", x_out); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (x_valid !== 1'b0 || busy !== 1'b0 || x_out !== 8'h00 || done !== 1'b0) begin
         fails++; $display("FAIL midrst_clear: got x_out %h valid %b busy %b done %b want 00 0 0 0",
                           x_out, x_valid, busy, done);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL midrst_after: got done %b busy %b want 0 0", done, busy);
      end
   endtask

   task automatic test_lfsr;
      logic [7:0] exp;
      for (int run = 0; run < 2; run++) begin
         int got = 0;
         int cyc = 0;
`ifdef FILTER_SAMPLE_GEN_LFSR_EN
         sb.push_back(8'hE1); sb.push_back(8'h70); sb.push_back(8'h38);
`else
         sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
`endif
         x_ready = 1'b1;
         pulse_start(3'd4, 8'hFF, 8'h00, 16'd3);
         while (got < 3 && cyc < 40) begin
            if (x_valid && x_ready) begin
               exp = sb.pop_front();
               tests++; if (x_out !== exp) begin fails++; $display("FAIL lfsr_r%0d_k%0d: got %h want %h", run, got, x_out, exp); end
               got++;
            end
            @(negedge clk); cyc++;
         end
         tests++; if (got != 3) begin fails++; $display("FAIL lfsr_timeout: got %0d transfers want 3", got); end
         sb.delete();
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; amplitude = '0; period = '0;
      num_samples = '0; x_ready = 1'b1;
      test_reset();
      test_impulse();
      test_square();
      test_back_to_back();
      test_abort();
      test_reset_midstream();
      test_lfsr();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
